// File: rtl/sr_control_pkg.sv
// Shared types and encodings for the schoolRISCV multi-cycle control unit.
// The optional extended branches are enabled with SR_CONTROL_BRANCH_EXT_EN.
package sr_control_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_IMMU = 2'd1,
    WD_MEM  = 2'd2
  } wdsrc_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam int unsigned ALU_W = 3;
  localparam logic [ALU_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR    = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SRL   = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SUB   = 3'b100;
  localparam logic [ALU_W-1:0] ALU_KSLL8 = 3'b101;

  localparam logic [6:0] RVOP_ADDI  = 7'b0010011;
  localparam logic [6:0] RVOP_BEQ   = 7'b1100011;
  localparam logic [6:0] RVOP_LUI   = 7'b0110111;
  localparam logic [6:0] RVOP_ADD   = 7'b0110011;
  localparam logic [6:0] RVOP_LW    = 7'b0000011;
  localparam logic [6:0] RVOP_SW    = 7'b0100011;
  localparam logic [6:0] RVOP_KSLL8 = 7'b1110111;

  localparam logic [2:0] RVF3_ADD  = 3'b000;
  localparam logic [2:0] RVF3_OR   = 3'b110;
  localparam logic [2:0] RVF3_SRL  = 3'b101;
  localparam logic [2:0] RVF3_SLTU = 3'b011;
  localparam logic [2:0] RVF3_BEQ  = 3'b000;
  localparam logic [2:0] RVF3_BNE  = 3'b001;
  localparam logic [2:0] RVF3_BLT  = 3'b100;
  localparam logic [2:0] RVF3_BGE  = 3'b101;
  localparam logic [2:0] RVF3_BLTU = 3'b110;
  localparam logic [2:0] RVF3_BGEU = 3'b111;
  localparam logic [2:0] RVF3_LW   = 3'b010;
  localparam logic [2:0] RVF3_SW   = 3'b010;

  localparam logic [6:0] RVF7_ADD    = 7'b0000000;
  localparam logic [6:0] RVF7_SUB    = 7'b0100000;
  localparam logic [6:0] RVF7_KSLL8  = 7'b0101100;
  localparam logic [6:0] RVF7_KSLLI8 = 7'b0111110;

  // condZero is the branch polarity: taken when the selected flag equals it
  typedef struct packed {
    logic             regWrite;
    logic             aluSrc;
    wdsrc_e           wdSrc;
    logic [ALU_W-1:0] aluControl;
    logic             isBranch;
    logic             condZero;
    logic             useLt;
    logic             ltUnsigned;
    logic             isLoad;
    logic             isStore;
    logic             illegal;
  } ctrl_t;

endpackage

// File: rtl/sr_control_mc_decode.sv
// Combinational instruction decoder: opcode/funct3/funct7 -> ctrl_t.
// BLT/BGE/BLTU/BGEU decode only when SR_CONTROL_BRANCH_EXT_EN is defined.
module sr_decode
  import sr_control_pkg::*;
(
  input  logic [6:0] cmdOp_i,
  input  logic [2:0] cmdF3_i,
  input  logic [6:0] cmdF7_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o            = '0;
    ctrl_o.wdSrc      = WD_ALU;
    ctrl_o.aluControl = ALU_ADD;
    casez ({cmdF7_i, cmdF3_i, cmdOp_i})
      {RVF7_ADD,    RVF3_ADD,  RVOP_ADD}:   ctrl_o.regWrite = 1'b1;
      {RVF7_ADD,    RVF3_OR,   RVOP_ADD}:   begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_OR;    end
      {RVF7_ADD,    RVF3_SRL,  RVOP_ADD}:   begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_SRL;   end
      {RVF7_ADD,    RVF3_SLTU, RVOP_ADD}:   begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_SLTU;  end
      {RVF7_SUB,    RVF3_ADD,  RVOP_ADD}:   begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_SUB;   end
      {RVF7_KSLL8,  RVF3_ADD,  RVOP_KSLL8}: begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_KSLL8; end
      {RVF7_KSLLI8, RVF3_ADD,  RVOP_KSLL8}: begin
        ctrl_o.regWrite = 1'b1; ctrl_o.aluSrc = 1'b1; ctrl_o.aluControl = ALU_KSLL8;
      end
      {7'b???????, RVF3_ADD, RVOP_ADDI}: begin ctrl_o.regWrite = 1'b1; ctrl_o.aluSrc = 1'b1; end
      {7'b???????, 3'b???,   RVOP_LUI}:  begin ctrl_o.regWrite = 1'b1; ctrl_o.wdSrc = WD_IMMU; end
      {7'b???????, RVF3_BEQ, RVOP_BEQ}: begin
        ctrl_o.isBranch = 1'b1; ctrl_o.condZero = 1'b1; ctrl_o.aluControl = ALU_SUB;
      end
      {7'b???????, RVF3_BNE, RVOP_BEQ}: begin
        ctrl_o.isBranch = 1'b1; ctrl_o.aluControl = ALU_SUB;
      end
`ifdef SR_CONTROL_BRANCH_EXT_EN
      {7'b???????, RVF3_BLT, RVOP_BEQ}: begin
        ctrl_o.isBranch = 1'b1; ctrl_o.useLt = 1'b1; ctrl_o.condZero = 1'b1; ctrl_o.aluControl = ALU_SUB;
      end
      {7'b???????, RVF3_BGE, RVOP_BEQ}: begin
        ctrl_o.isBranch = 1'b1; ctrl_o.useLt = 1'b1; ctrl_o.aluControl = ALU_SUB;
      end
      {7'b???????, RVF3_BLTU, RVOP_BEQ}: begin
        ctrl_o.isBranch = 1'b1; ctrl_o.useLt = 1'b1; ctrl_o.ltUnsigned = 1'b1;
        ctrl_o.condZero = 1'b1; ctrl_o.aluControl = ALU_SUB;
      end
      {7'b???????, RVF3_BGEU, RVOP_BEQ}: begin
        ctrl_o.isBranch = 1'b1; ctrl_o.useLt = 1'b1; ctrl_o.ltUnsigned = 1'b1; ctrl_o.aluControl = ALU_SUB;
      end
`endif
      {7'b???????, RVF3_LW, RVOP_LW}: begin
        ctrl_o.regWrite = 1'b1; ctrl_o.aluSrc = 1'b1; ctrl_o.wdSrc = WD_MEM; ctrl_o.isLoad = 1'b1;
      end
      {7'b???????, RVF3_SW, RVOP_SW}: begin
        ctrl_o.aluSrc = 1'b1; ctrl_o.isStore = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sr_control_mc.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with shared memory handshake and traps.
// Define SR_CONTROL_BRANCH_EXT_EN to enable BLT/BGE/BLTU/BGEU.
module sr_control_mc
  import sr_control_pkg::*;
#(
  parameter int unsigned ALUC_W      = 4,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        cmdOp,
  input  logic [2:0]        cmdF3,
  input  logic [6:0]        cmdF7,
  input  logic              aluZero,
  input  logic              aluLtS,
  input  logic              aluLtU,
  input  logic              memReady,
  output logic              memReq,
  output logic              memWe,
  output logic              irWrite,
  output logic              pcWrite,
  output logic              pcSrc,
  output logic              regWrite,
  output logic              aluSrc,
  output logic [1:0]        wdSrc,
  output logic [ALUC_W-1:0] aluControl,
  output logic              trap,
  output logic [1:0]        trapCause,
  output logic [2:0]        fsmState
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d, dec;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic             run_q;
  logic             req_w, to_hit, br_cond, unused_ok;
  logic [ALU_W-1:0] alu_w;

  sr_decode u_decode (
    .cmdOp_i (cmdOp),
    .cmdF3_i (cmdF3),
    .cmdF7_i (cmdF7),
    .ctrl_o  (dec)
  );

  // run_q holds strobes off through the cycle in which rst_n is released
  assign req_w = run_q && (state_q == FETCH || state_q == MEM);

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);
      logic [TO_W-1:0] cnt_q, cnt_d;
      assign to_hit = req_w && !memReady && (cnt_q == TO_W'(MEM_TIMEOUT - 1));
      always_comb begin
        cnt_d = cnt_q + TO_W'(1);
        if (!req_w || memReady || to_hit) cnt_d = '0;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end else begin : g_no_timeout
      assign to_hit = 1'b0;
    end
  endgenerate

`ifdef SR_CONTROL_BRANCH_EXT_EN
  assign br_cond   = ctrl_q.useLt ? (ctrl_q.ltUnsigned ? aluLtU : aluLtS) : aluZero;
  assign unused_ok = ctrl_q.illegal;
`else
  assign br_cond   = aluZero;
  assign unused_ok = ^{aluLtS, aluLtU, ctrl_q.useLt, ctrl_q.ltUnsigned, ctrl_q.illegal};
`endif

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    memWe    = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 1'b0;
    regWrite = 1'b0;
    aluSrc   = 1'b0;
    wdSrc    = WD_ALU;
    alu_w    = ALU_ADD;
    if (run_q) begin
      unique case (state_q)
        FETCH: begin
          if (memReady) begin
            irWrite = 1'b1;
            state_d = DECODE;
          end else if (to_hit) begin
            trap_d  = 1'b1;
            cause_d = CAUSE_TIMEOUT;
            state_d = TRAP;
          end
        end
        DECODE: begin
          ctrl_d = dec;
          if (dec.illegal) begin
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
            state_d = TRAP;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          aluSrc = ctrl_q.aluSrc;
          alu_w  = ctrl_q.aluControl;
          if (ctrl_q.isLoad || ctrl_q.isStore) begin
            state_d = MEM;
          end else begin
            pcWrite = 1'b1;
            state_d = FETCH;
            if (ctrl_q.isBranch) begin
              pcSrc = (br_cond == ctrl_q.condZero);
            end else begin
              regWrite = ctrl_q.regWrite;
              wdSrc    = ctrl_q.wdSrc;
            end
          end
        end
        MEM: begin
          memWe  = ctrl_q.isStore;
          aluSrc = ctrl_q.aluSrc;
          alu_w  = ctrl_q.aluControl;
          if (memReady) begin
            if (ctrl_q.isStore) begin
              pcWrite = 1'b1;
              state_d = FETCH;
            end else begin
              state_d = WB;
            end
          end else if (to_hit) begin
            trap_d  = 1'b1;
            cause_d = CAUSE_TIMEOUT;
            state_d = TRAP;
          end
        end
        WB: begin
          regWrite = 1'b1;
          wdSrc    = WD_MEM;
          pcWrite  = 1'b1;
          state_d  = FETCH;
        end
        TRAP:    state_d = TRAP;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctrl_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      run_q   <= 1'b1;
    end
  end

  assign memReq     = req_w;
  assign aluControl = ALUC_W'(alu_w);
  assign trap       = trap_q;
  assign trapCause  = cause_q;
  assign fsmState   = state_q;

endmodule

// File: tb/tb_sr_control_mc.sv
// Directed self-checking bench for sr_control_mc (default build, MEM_TIMEOUT=4).
module tb_sr_control_mc;

  logic       clk, rst_n;
  logic [6:0] cmdOp, cmdF7;
  logic [2:0] cmdF3;
  logic       aluZero, aluLtS, aluLtU, memReady;
  logic       memReq, memWe, irWrite, pcWrite, pcSrc, regWrite, aluSrc, trap;
  logic [1:0] wdSrc, trapCause;
  logic [3:0] aluControl;
  logic [2:0] fsmState;

  int checks = 0;
  int errors = 0;

  sr_control_mc #(.ALUC_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
    .aluZero(aluZero), .aluLtS(aluLtS), .aluLtU(aluLtU), .memReady(memReady),
    .memReq(memReq), .memWe(memWe), .irWrite(irWrite), .pcWrite(pcWrite),
    .pcSrc(pcSrc), .regWrite(regWrite), .aluSrc(aluSrc), .wdSrc(wdSrc),
    .aluControl(aluControl), .trap(trap), .trapCause(trapCause), .fsmState(fsmState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  strb;
  logic [18:0] allo;
  assign strb = {memReq, memWe, irWrite, pcWrite, pcSrc, regWrite, aluSrc};
  assign allo = {strb, wdSrc, aluControl, trap, trapCause, fsmState};

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic       ill;
    logic [2:0] nxt;
    logic [9:0] ex;   // {regWrite,pcWrite,pcSrc,aluSrc,wdSrc,aluControl} in EXEC
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input string n, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic z, input logic ill,
                              input logic [2:0] nxt, input logic [9:0] ex);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.ill = ill; v.nxt = nxt; v.ex = ex;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench sampling cycle 1 (first FETCH cycle after reset release)
  task automatic reset_dut(input logic rdy);
    rst_n = 1'b0;
    memReady = rdy;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(allo), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_quiet", 32'({strb, fsmState}), 32'd0);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cnt, quiet, rw_seen;
    rst_n = 1'b0; cmdOp = '0; cmdF3 = '0; cmdF7 = '0;
    aluZero = 1'b0; aluLtS = 1'b0; aluLtU = 1'b0; memReady = 1'b0;

    add("ADD",    7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'd0, 10'b1100000000);
    add("SUB",    7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0, 3'd0, 10'b1100000100);
    add("OR",     7'b0110011, 3'b110, 7'b0000000, 1'b0, 1'b0, 3'd0, 10'b1100000001);
    add("SRL",    7'b0110011, 3'b101, 7'b0000000, 1'b0, 1'b0, 3'd0, 10'b1100000010);
    add("SLTU",   7'b0110011, 3'b011, 7'b0000000, 1'b0, 1'b0, 3'd0, 10'b1100000011);
    add("KSLL8",  7'b1110111, 3'b000, 7'b0101100, 1'b0, 1'b0, 3'd0, 10'b1100000101);
    add("KSLLI8", 7'b1110111, 3'b000, 7'b0111110, 1'b0, 1'b0, 3'd0, 10'b1101000101);
    add("ADDI",   7'b0010011, 3'b000, 7'b1010101, 1'b0, 1'b0, 3'd0, 10'b1101000000);
    add("LUI",    7'b0110111, 3'b101, 7'b0011001, 1'b0, 1'b0, 3'd0, 10'b1100010000);
    add("BEQ_z1", 7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0, 3'd0, 10'b0110000100);
    add("BEQ_z0", 7'b1100011, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'd0, 10'b0100000100);
    add("BNE_z1", 7'b1100011, 3'b001, 7'b0000000, 1'b1, 1'b0, 3'd0, 10'b0100000100);
    add("BNE_z0", 7'b1100011, 3'b001, 7'b0000000, 1'b0, 1'b0, 3'd0, 10'b0110000100);
    add("LW",     7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, 3'd3, 10'b0001000000);
    add("SW",     7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, 3'd3, 10'b0001000000);
    add("OP_7F",  7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b1, 3'd5, 10'b0);
    add("BLT",    7'b1100011, 3'b100, 7'b0000000, 1'b0, 1'b1, 3'd5, 10'b0);
    add("ADD_F7", 7'b0110011, 3'b000, 7'b0000001, 1'b0, 1'b1, 3'd5, 10'b0);
    add("LB",     7'b0000011, 3'b000, 7'b0000000, 1'b0, 1'b1, 3'd5, 10'b0);

    // Zero-wait memory: FETCH@1, DECODE@2, EXEC@3, next state @4
    foreach (vecs[i]) begin
      cmdOp = vecs[i].op; cmdF3 = vecs[i].f3; cmdF7 = vecs[i].f7; aluZero = vecs[i].z;
      reset_dut(1'b1);
      chk({vecs[i].name, "_fetch"}, 32'({strb, fsmState}), 32'({7'b1010000, 3'd0}));
      nxt();
      chk({vecs[i].name, "_decode"}, 32'({strb, fsmState}), 32'({7'b0000000, 3'd1}));
      nxt();
      if (vecs[i].ill) begin
        chk({vecs[i].name, "_trap"}, 32'({trap, trapCause, fsmState}), 32'({1'b1, 2'd1, 3'd5}));
        quiet = 0;
        for (int c = 0; c < 10; c++) begin
          nxt();
          if (strb != 7'd0 || fsmState != 3'd5 || trap != 1'b1) quiet++;
        end
        chk({vecs[i].name, "_trap_quiet"}, 32'(quiet), 32'd0);
      end else begin
        chk({vecs[i].name, "_exec"}, 32'({memReq, memWe, irWrite, regWrite, pcWrite, pcSrc, aluSrc, wdSrc, aluControl}),
            32'({3'b000, vecs[i].ex}));
        nxt();
        chk({vecs[i].name, "_next"}, 32'(fsmState), 32'(vecs[i].nxt));
      end
    end

    // LW with memReady delayed 3 cycles in MEM
    cmdOp = 7'b0000011; cmdF3 = 3'b010; cmdF7 = 7'b0000000;
    reset_dut(1'b1);
    nxt(); nxt();
    memReady = 1'b0;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      nxt();
      if ({memReq, memWe, aluSrc, aluControl, regWrite, pcWrite, fsmState} == {3'b101, 4'd0, 2'b00, 3'd3}) cnt++;
    end
    nxt();
    memReady = 1'b1;
    #1;
    if ({memReq, memWe, aluSrc, aluControl, regWrite, pcWrite, fsmState} == {3'b101, 4'd0, 2'b00, 3'd3}) cnt++;
    chk("lw_mem_hold", 32'(cnt), 32'd4);
    nxt();
    chk("lw_wb", 32'({regWrite, wdSrc, pcWrite, pcSrc, memReq, fsmState}), 32'({1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 3'd4}));
    nxt();
    chk("lw_back_fetch", 32'({fsmState, trap}), 32'({3'd0, 1'b0}));

    // SW with memReady delayed 2 cycles in MEM
    cmdOp = 7'b0100011; cmdF3 = 3'b010;
    reset_dut(1'b1);
    rw_seen = int'(regWrite);
    nxt(); rw_seen += int'(regWrite);
    nxt(); rw_seen += int'(regWrite);
    memReady = 1'b0;
    cnt = 0;
    for (int c = 0; c < 2; c++) begin
      nxt();
      rw_seen += int'(regWrite);
      if ({memReq, memWe, aluSrc, pcWrite, fsmState} == {4'b1110, 3'd3}) cnt++;
    end
    chk("sw_mem_wait", 32'(cnt), 32'd2);
    nxt();
    memReady = 1'b1;
    #1;
    rw_seen += int'(regWrite);
    chk("sw_ready", 32'({memReq, memWe, pcWrite, pcSrc}), 32'(4'b1110));
    nxt();
    rw_seen += int'(regWrite);
    chk("sw_back_fetch", 32'(fsmState), 32'd0);
    chk("sw_no_regwrite", 32'(rw_seen), 32'd0);

    // Fetch timeout with MEM_TIMEOUT=4
    reset_dut(1'b0);
    cnt = int'(memReq && !trap);
    for (int c = 0; c < 3; c++) begin
      nxt();
      if (memReq && !trap) cnt++;
    end
    chk("timeout_wait", 32'(cnt), 32'd4);
    nxt();
    chk("timeout_trap", 32'({memReq, trap, trapCause, fsmState}), 32'({1'b0, 1'b1, 2'd2, 3'd5}));

    // Asynchronous reset in the middle of a pending fetch
    reset_dut(1'b0);
    nxt();
    chk("midwait_req", 32'(memReq), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midwait_reset", 32'({strb, fsmState, trap}), 32'd0);
    rst_n = 1'b1;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
